bit_bus_initiator: RTL and testbench

- Initiator (master) for the team's 1-bit register/FIFO bus: write_address/write_data/write_en/write_rdy plus read_address/read_en/read_data/read_rdy.
- Accepts a queue of read/write commands from a local controller over valid/ready.
- Issues each command to the target only when the target's rdy permits, and returns exactly one response per command, in order.
- Sits between a test sequencer or CPU-side logic and the target block's bus wrapper.

---
 rtl/bit_bus_initiator.sv | 146 ++++++++++++++
 tb/tb_bit_bus_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_bus_initiator.sv
// rtl/bit_bus_initiator.sv - 1-bit bus initiator with command FIFO, per-command timeout and in-order responses
module bit_bus_initiator #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_is_read,
    input  logic [2:0] cmd_addr,
    input  logic       cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_data,
    output logic       rsp_is_read,
    output logic       rsp_timeout,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic       busy
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = CMD_DEPTH;
    localparam logic [7:0]       TERM = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RESP} state_t;
    state_t state, state_next;

    // FIFO entry layout: {is_read, addr[2:0], wdata}
    logic [4:0]       fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [4:0]       head;
    logic             full, empty, push, pop;
    logic [7:0]       timer;
    logic             in_wait, rdy, timed_out;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = !empty || (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign write_en  = (state == WR_WAIT) && write_rdy && !reset;
    assign read_en   = (state == RD_WAIT) && read_rdy && !reset;
    assign in_wait   = (state == WR_WAIT) || (state == RD_WAIT);
    assign rdy       = (state == RD_WAIT) ? read_rdy : write_rdy;
    // A rdy arriving on the terminal count still wins over the timeout.
    assign timed_out = (TIMEOUT > 0) && !rdy && (timer == TERM);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_is_read, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head[4] ? RD_WAIT : WR_WAIT;
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (rdy || timed_out) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = head[4] ? RD_WAIT : WR_WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_address <= '0;
            write_data    <= 1'b0;
            read_address  <= '0;
            timer         <= '0;
            rsp_data      <= 1'b0;
            rsp_is_read   <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            if (pop) begin
                timer <= '0;
                if (head[4]) begin
                    read_address <= head[3:1];
                end else begin
                    write_address <= head[3:1];
                    write_data    <= head[0];
                end
            end else if (in_wait && !rdy) begin
                timer <= timer + 8'd1;
            end
            if (in_wait && rdy) begin
                rsp_data    <= (state == RD_WAIT) && read_data;
                rsp_is_read <= (state == RD_WAIT);
                rsp_timeout <= 1'b0;
            end else if (in_wait && timed_out) begin
                rsp_data    <= 1'b0;
                rsp_is_read <= (state == RD_WAIT);
                rsp_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_bus_initiator.sv
// tb/tb_bit_bus_initiator.sv - self-checking bench for bit_bus_initiator
module tb_bit_bus_initiator;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_is_read, cmd_wdata;
    logic [2:0] cmd_addr;
    logic       rsp_valid, rsp_ready, rsp_data, rsp_is_read, rsp_timeout;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy;
    logic       read_en, read_data, read_rdy;
    logic       busy;

    bit_bus_initiator #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(cmd_is_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_is_read(rsp_is_read), .rsp_timeout(rsp_timeout),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_read;
        logic [2:0] addr;
        logic       wdata;
    } cmd_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_strobes = 0;
    int rd_strobes = 0;
    logic [2:0] rsp_log[$];

    // Reference model: commands waiting, the one in flight, the response on offer
    cmd_t cmdq[$];
    cmd_t cur;
    bit   cur_active  = 0;
    bit   rsp_pending = 0;
    int   wait_cnt    = 0;
    logic e_is_read = 0, e_data = 0, e_to = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit   old_active, old_pending, do_pop, can_push, rdy;
        logic exp_we, exp_re;
        exp_we = cur_active && !cur.is_read && write_rdy && !reset;
        exp_re = cur_active && cur.is_read && read_rdy && !reset;
        check("cmd_ready", cmd_ready, cmdq.size() < DEPTH);
        check("busy", busy, (cmdq.size() > 0) || cur_active || rsp_pending);
        check("rsp_valid", rsp_valid, rsp_pending);
        if (rsp_pending) begin
            check("rsp_is_read", rsp_is_read, e_is_read);
            check("rsp_data", rsp_data, e_data);
            check("rsp_timeout", rsp_timeout, e_to);
        end
        check("write_en", write_en, exp_we);
        check("read_en", read_en, exp_re);
        if (exp_we) begin
            check("write_address", write_address, cur.addr);
            check("write_data", write_data, cur.wdata);
        end
        if (exp_re) check("read_address", read_address, cur.addr);

        if (write_en) wr_strobes++;
        if (read_en)  rd_strobes++;
        if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_is_read, rsp_data, rsp_timeout});

        if (reset) begin
            cmdq.delete();
            cur_active  = 0;
            rsp_pending = 0;
        end else begin
            old_active  = cur_active;
            old_pending = rsp_pending;
            can_push    = cmd_valid && (cmdq.size() < DEPTH);
            do_pop      = (cmdq.size() > 0) &&
                          ((!old_active && !old_pending) || (old_pending && rsp_ready));
            if (old_pending && rsp_ready) rsp_pending = 0;
            if (old_active) begin
                rdy = cur.is_read ? read_rdy : write_rdy;
                if (rdy) begin
                    rsp_pending = 1; cur_active = 0;
                    e_is_read = cur.is_read; e_data = cur.is_read ? read_data : 1'b0; e_to = 0;
                end else if (TMO > 0 && wait_cnt == TMO - 1) begin
                    rsp_pending = 1; cur_active = 0;
                    e_is_read = cur.is_read; e_data = 0; e_to = 1;
                end else begin
                    wait_cnt++;
                end
            end
            if (do_pop) begin
                cur = cmdq.pop_front();
                cur_active = 1;
                wait_cnt = 0;
            end
            if (can_push) cmdq.push_back({cmd_is_read, cmd_addr, cmd_wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit rd, input int a, input bit d);
        int n;
        bit ok;
        n = 0;
        cmd_valid = 1; cmd_is_read = rd; cmd_addr = a[2:0]; cmd_wdata = d;
        do begin
            ok = cmd_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        if (!ok) check("push_bound", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, rsp_valid, 1);
    endtask

    initial begin
        int s0, r0, l0, c0, n;
        reset = 1; cmd_valid = 0; cmd_is_read = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; write_rdy = 0; read_rdy = 0; read_data = 0;
        repeat (3) tick();
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_strobes", {write_en, read_en}, 2'b00);
        check("rst_rsp_fields", {rsp_data, rsp_is_read, rsp_timeout}, 3'b000);
        check("rst_addr", {write_address, read_address, write_data}, 7'd0);
        reset = 0;
        tick();

        // Single write, bus always ready
        write_rdy = 1; read_rdy = 1; rsp_ready = 1;
        s0 = wr_strobes;
        push(0, 4, 1);
        #2 check("w_idle_no_strobe", write_en, 0);
        tick();
        #2;
        check("w_strobe", write_en, 1);
        check("w_addr", write_address, 3'd4);
        check("w_data", write_data, 1);
        tick();
        #2;
        check("w_rsp_valid", rsp_valid, 1);
        check("w_rsp_kind", {rsp_is_read, rsp_timeout}, 2'b00);
        repeat (2) tick();
        check("w_one_strobe", wr_strobes - s0, 1);

        // Read stalled for 5 cycles
        read_rdy = 0; read_data = 0;
        r0 = rd_strobes;
        push(1, 3, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #2 check("r_stall", read_en, 0);
            tick();
        end
        read_rdy = 1; read_data = 1;
        #2;
        check("r_strobe", read_en, 1);
        check("r_addr", read_address, 3'd3);
        tick();
        #2;
        check("r_rsp_valid", rsp_valid, 1);
        check("r_rsp", {rsp_is_read, rsp_data, rsp_timeout}, 3'b110);
        repeat (2) tick();
        check("r_one_strobe", rd_strobes - r0, 1);

        // Queue filling under response backpressure
        rsp_ready = 0; write_rdy = 1; read_rdy = 1; read_data = 1;
        l0 = rsp_log.size();
        s0 = wr_strobes + rd_strobes;
        push(0, 4, 1); push(0, 5, 0); push(1, 3, 0); push(1, 0, 0); push(0, 7, 1);
        #2 check("q_full", cmd_ready, 0);
        r0 = wr_strobes + rd_strobes;
        repeat (10) tick();
        check("q_no_strobe", wr_strobes + rd_strobes - r0, 0);
        check("q_held", rsp_valid, 1);
        rsp_ready = 1;
        n = 0;
        while (rsp_log.size() < l0 + 5 && n < 300) begin
            tick();
            n++;
        end
        check("q_drain", rsp_log.size(), l0 + 5);
        if (rsp_log.size() >= l0 + 5) begin
            check("q_rsp0", rsp_log[l0 + 0], 3'b000);
            check("q_rsp1", rsp_log[l0 + 1], 3'b000);
            check("q_rsp2", rsp_log[l0 + 2], 3'b110);
            check("q_rsp3", rsp_log[l0 + 3], 3'b110);
            check("q_rsp4", rsp_log[l0 + 4], 3'b000);
        end
        check("q_strobes", wr_strobes + rd_strobes - s0, 5);

        // Timeout on a stuck write, then a queued read proceeds
        repeat (3) tick();
        write_rdy = 0; read_rdy = 1; read_data = 1; rsp_ready = 1;
        s0 = wr_strobes;
        push(0, 2, 1);
        c0 = cyc;
        push(1, 6, 0);
        wait_rsp("t_rsp_bound");
        check("t_latency", cyc - c0, TMO + 1);
        check("t_rsp", {rsp_is_read, rsp_data, rsp_timeout}, 3'b001);
        tick();
        wait_rsp("t_next_bound");
        check("t_next_rsp", {rsp_is_read, rsp_data, rsp_timeout}, 3'b110);
        check("t_no_write", wr_strobes - s0, 0);
        repeat (2) tick();

        // rdy arriving on the terminal-count cycle
        write_rdy = 0;
        push(0, 1, 1);
        repeat (TMO) tick();
        write_rdy = 1;
        #2 check("b_strobe", write_en, 1);
        tick();
        #2;
        check("b_rsp_valid", rsp_valid, 1);
        check("b_no_timeout", rsp_timeout, 0);
        repeat (2) tick();

        // Reset in the middle of a read
        read_rdy = 0;
        push(1, 5, 0);
        push(0, 2, 1);
        tick();
        read_rdy = 1; reset = 1;
        #2 check("x_read_en", read_en, 0);
        tick();
        reset = 0;
        #2;
        check("x_rsp_valid", rsp_valid, 0);
        check("x_busy", busy, 0);
        check("x_cmd_ready", cmd_ready, 1);
        l0 = rsp_log.size();
        r0 = wr_strobes + rd_strobes;
        repeat (4) tick();
        check("x_no_rsp", rsp_log.size() - l0, 0);
        check("x_no_strobe", wr_strobes + rd_strobes - r0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) < 20) begin
                write_rdy = 0;
                read_rdy  = 0;
            end else begin
                write_rdy = ($urandom_range(0, 99) < 65);
                read_rdy  = ($urandom_range(0, 99) < 65);
            end
            read_data   = 1'($urandom_range(0, 1));
            rsp_ready   = ($urandom_range(0, 3) != 0);
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_is_read = 1'($urandom_range(0, 1));
            cmd_addr    = 3'($urandom_range(0, 7));
            cmd_wdata   = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_valid = 0; write_rdy = 1; read_rdy = 1; rsp_ready = 1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("drain_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
